// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed from a small circular-buffer byte FIFO.
// A frame starts on the edge after a byte is queued; consecutive frames run back to back.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (0) on the line
// DATA  | data bits, LSB first
// STOP  | stop bit (1); pops the next byte on exit if one is queued
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [15:0]      BIT_LAST = 16'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [1:0]       state_q,   state_d;
    logic [15:0]      bit_cnt_q, bit_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             tx_q,      tx_d;
    logic [PTR_W-1:0] wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,  rd_ptr_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [7:0]       mem_d [FIFO_DEPTH];

    logic push;
    logic pop;
    logic bit_done;

    always_comb begin
        // Full check uses the registered count, so a same-edge pop never frees a slot early.
        push     = data_valid && (count_q != CNT_FULL);
        bit_done = (bit_cnt_q == '0);
        pop      = (count_q != '0) &&
                   ((state_q == IDLE) || ((state_q == STOP) && bit_done));

        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;

        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (pop) begin
                    shift_d   = mem_q[rd_ptr_q];
                    tx_d      = 1'b0;
                    bit_cnt_d = BIT_LAST;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    tx_d      = shift_q[0];
                    bit_idx_d = 3'd0;
                    bit_cnt_d = BIT_LAST;
                    state_d   = DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            DATA: begin
                if (bit_done) begin
                    bit_cnt_d = BIT_LAST;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    if (pop) begin
                        shift_d   = mem_q[rd_ptr_q];
                        tx_d      = 1'b0;
                        bit_cnt_d = BIT_LAST;
                        state_d   = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            default: begin
                tx_d      = 1'b1;
                bit_cnt_d = '0;
                state_d   = IDLE;
            end
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign tx         = tx_q;
    assign tx_busy    = (state_q != IDLE);
    assign fifo_count = count_q;
    assign data_ready = (count_q != CNT_FULL);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a queue-based frame model checked every cycle, plus directed
// literal checks for single frame, back-to-back, full FIFO, same-edge push/pop and reset.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clock;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       tx;
    logic       tx_busy;
    logic [2:0] fifo_count;

    int total = 0;
    int bad   = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Model: a byte queue plus the in-flight byte and its position (0..10*CPB-1) in the frame.
    logic [7:0] q_m [$];
    logic [7:0] cur_m;
    logic       act_m;
    int         pos_m;
    logic       model_on = 1'b0;
    logic       push_m;

    initial forever begin
        @(posedge clock);
        if (reset) begin
            q_m.delete();
            act_m    = 1'b0;
            pos_m    = 0;
            model_on = 1'b1;
        end else if (model_on) begin
            push_m = data_valid && (q_m.size() < DEPTH);
            if (act_m && pos_m < 10*CPB-1) begin
                pos_m++;
            end else if (q_m.size() > 0) begin
                cur_m = q_m.pop_front();
                act_m = 1'b1;
                pos_m = 0;
            end else begin
                act_m = 1'b0;
            end
            if (push_m) q_m.push_back(data_in);
        end
    end

    function automatic logic exp_tx();
        int k;
        if (!act_m) return 1'b1;
        k = pos_m / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return cur_m[k-1];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clock);
        if (model_on) begin
            check("tx",         32'(tx),         32'(exp_tx()));
            check("tx_busy",    32'(tx_busy),    32'(act_m));
            check("fifo_count", 32'(fifo_count), 32'(q_m.size()));
            check("data_ready", 32'(data_ready), 32'(q_m.size() != DEPTH));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int n;
        n = 0;
        data_in    = b;
        data_valid = 1'b1;
        while (!data_ready && n < 2000) begin
            tick();
            n++;
        end
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL push_timeout: byte %0h never accepted", b);
        end
        tick();
        data_valid = 1'b0;
        data_in    = 8'($urandom);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((tx_busy || fifo_count != 0) && n < 5000) begin
            tick();
            n++;
        end
        if (n >= 5000) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: busy=%0d count=%0d", tx_busy, fifo_count);
        end
        tick();
        tick();
    endtask

    bit a5_bits [8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    initial begin
        logic lit;
        reset      = 1'b1;
        data_valid = 1'b0;
        data_in    = 8'h00;
        repeat (3) tick();
        check("rst_tx",    32'(tx),         32'd1);
        check("rst_busy",  32'(tx_busy),    32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_ready", 32'(data_ready), 32'd1);
        reset = 1'b0;
        tick();

        // Single 0xA5 frame, data_in scrambled right after acceptance.
        data_in = 8'hA5; data_valid = 1'b1;
        tick();
        data_valid = 1'b0; data_in = 8'($urandom);
        for (int k = 1; k <= 44; k++) begin
            tick();
            if (k <= 4)       lit = 1'b0;
            else if (k <= 36) lit = a5_bits[(k-5)/4];
            else              lit = 1'b1;
            check("a5_tx", 32'(tx), 32'(lit));
            if (k == 40) check("a5_busy_stop", 32'(tx_busy), 32'd1);
            if (k == 41) check("a5_busy_end",  32'(tx_busy), 32'd0);
        end

        // Back-to-back 0x00, 0xFF.
        data_in = 8'h00; data_valid = 1'b1;
        tick();
        data_in = 8'hFF;
        tick();
        data_valid = 1'b0;
        for (int k = 2; k <= 41; k++) begin
            tick();
            if (k == 40) check("b2b_stop1",  32'(tx), 32'd1);
            if (k == 41) check("b2b_start2", 32'(tx), 32'd0);
            if (k == 41) check("b2b_busy",   32'(tx_busy), 32'd1);
        end
        wait_idle();

        // Full FIFO with valid held high; sixth byte waits for the STOP-exit pop.
        data_valid = 1'b1;
        for (int b = 0; b < 5; b++) begin
            data_in = 8'h10 + 8'(b);
            tick();
        end
        check("full_count", 32'(fifo_count), 32'd4);
        check("full_ready", 32'(data_ready), 32'd0);
        data_in = 8'h15;
        repeat (37) tick();
        check("full_pop_count", 32'(fifo_count), 32'd3);
        check("full_pop_ready", 32'(data_ready), 32'd1);
        tick();
        data_valid = 1'b0;
        check("full_refill", 32'(fifo_count), 32'd4);
        wait_idle();

        // Push on the exact STOP-exit pop edge with one byte queued.
        data_valid = 1'b1; data_in = 8'h3C;
        tick();
        data_in = 8'hC3;
        tick();
        data_valid = 1'b0;
        repeat (39) tick();
        check("pp_before", 32'(fifo_count), 32'd1);
        data_in = 8'h5A; data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        check("pp_count", 32'(fifo_count), 32'd1);
        check("pp_tx",    32'(tx),         32'd0);
        check("pp_busy",  32'(tx_busy),    32'd1);
        wait_idle();

        // Reset during data bit 3 with two bytes queued; valid during reset is ignored.
        data_valid = 1'b1;
        data_in = 8'h71; tick();
        data_in = 8'h72; tick();
        data_in = 8'h73; tick();
        data_valid = 1'b0;
        repeat (16) tick();
        check("mid_count", 32'(fifo_count), 32'd2);
        reset = 1'b1; data_valid = 1'b1; data_in = 8'($urandom);
        tick();
        reset = 1'b0; data_valid = 1'b0;
        check("mr_tx",    32'(tx),         32'd1);
        check("mr_count", 32'(fifo_count), 32'd0);
        check("mr_busy",  32'(tx_busy),    32'd0);
        check("mr_ready", 32'(data_ready), 32'd1);
        repeat (60) tick();
        check("mr_quiet", 32'(tx_busy), 32'd0);

        // Pointer wrap: 0x01..0x09 with random gaps.
        for (int b = 1; b <= 9; b++) begin
            repeat ($urandom_range(0, 15)) begin
                data_in = 8'($urandom);
                tick();
            end
            push_byte(8'(b));
        end
        wait_idle();

        // Random bytes: dense bursts first (often full), then sparse.
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, (i < 20) ? 3 : 60)) begin
                data_in = 8'($urandom);
                tick();
            end
            push_byte(8'($urandom));
        end
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clock cycles per UART bit (legal range 2..65535).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte entries in the transmit FIFO (power of two, 2..16).
REQ-003 SHALL have port clock  input  1  single clock for all logic.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_in  input  8  byte to transmit.
REQ-006 SHALL have port data_valid  input  1  data_in is offered this cycle.
REQ-007 SHALL have port data_ready  output  1  FIFO can accept a byte this cycle.
REQ-008 SHALL have port tx  output  1  UART serial line, idle high.
REQ-009 SHALL have port tx_busy  output  1  a frame is on the line (state not IDLE).
REQ-010 SHALL have port fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being shifted.

Function
REQ-011 SHALL use frame format 8N1: one start bit (0), eight data bits LSB first, one stop bit (1), no parity.
REQ-012 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles; one frame = 10*CLKS_PER_BIT cycles.
REQ-013 SHALL drive tx from a register (no combinational path from any input to tx).
REQ-014 SHALL drive data_ready = (fifo_count != FIFO_DEPTH), combinationally from the count only.
REQ-015 SHALL accept a byte on a rising edge where data_valid && data_ready; data_valid while data_ready is low SHALL be ignored, with no FIFO or state change.
REQ-016 SHALL NOT accept a push when full, even if a pop occurs on the same edge.
REQ-017 SHALL on a push and a pop on the same edge leave fifo_count unchanged and preserve FIFO order.
REQ-018 SHALL implement the FIFO as a circular buffer; read and write pointers SHALL wrap from FIFO_DEPTH-1 to 0.
REQ-019 SHALL implement states IDLE, START, DATA, STOP with a bit-period counter and a 3-bit data index.
REQ-020 IDLE: tx=1. If fifo_count>0, SHALL on the next edge pop the head byte into the shift register, drive tx=0 and enter START.
REQ-021 START: after CLKS_PER_BIT cycles, SHALL enter DATA with tx=bit 0.
REQ-022 DATA: after each CLKS_PER_BIT cycles, SHALL advance to the next bit; after bit 7 has been held for its full period, SHALL drive tx=1 and enter STOP.
REQ-023 STOP: after CLKS_PER_BIT cycles, if fifo_count>0, SHALL pop, drive tx=0 and enter START on that same edge, with no idle gap; otherwise it SHALL enter IDLE.
REQ-024 Latency: byte accepted at edge E into an empty FIFO while IDLE SHALL produce tx=0 from edge E+1.
REQ-025 SHALL capture data_in at acceptance; later changes to data_in SHALL NOT affect queued or in-flight bytes.
REQ-026 SHALL allow pushes during any state; the byte being shifted SHALL NOT occupy a FIFO entry.

Reset
REQ-027 On reset high at a rising edge: state=IDLE, tx=1, tx_busy=0, fifo_count=0, pointers=0, counters=0, data_ready=1.
REQ-028 Reset asserted mid-frame SHALL abort the frame immediately: tx=1 from the reset edge, and all queued bytes are discarded.
REQ-029 data_valid while reset is high SHALL be ignored.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-030 Single byte: push 0xA5 at edge E -> tx=0 during E+1..E+4, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then tx=1; tx_busy=0 from edge E+41.
REQ-031 Back-to-back: push 0x00 then 0xFF on consecutive cycles -> two contiguous 40-cycle frames; the second start bit begins the cycle after the first stop bit ends.
REQ-032 Full: push 6 bytes with data_valid held high -> first popped into shifter, next 4 queued, fifo_count=4, data_ready=0; 6th byte held off until the pop at the first frame's STOP end, then accepted; all 6 bytes appear on tx in order.
REQ-033 Simultaneous push/pop: count=1, push on the exact STOP-exit pop edge -> fifo_count stays 1, order preserved.
REQ-034 Reset mid-frame: assert reset during DATA bit 3 with 2 bytes queued -> tx=1, fifo_count=0, tx_busy=0 next cycle; no further frames.
REQ-035 Pointer wrap: push and transmit 9 bytes 0x01..0x09 with random valid gaps -> received sequence exactly 0x01..0x09.
